fsm_sequence_checker_param: RTL and testbench

// - Parametrised successor of the ASCII sequence checker: validates delimiter-framed character streams from the UART/char front end.
// - Frame = DELIM, body, DELIM; body checked for character class, operand/operator order and length.
// - Reports per-frame verdict + error code + length; keeps saturating good/bad frame counters for the status block.

---
 rtl/fsm_sequence_checker_param_pkg.sv | 34 +++
 rtl/fsm_sequence_checker_param_classifier.sv | 33 +++
 rtl/fsm_sequence_checker_param.sv | 203 ++++++++++++++++++++
 tb/tb_fsm_sequence_checker_param.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fsm_sequence_checker_param_pkg.sv
// Shared types and constants for the delimiter-framed ASCII sequence checker.
// Holds state encodings, verdict codes, ASCII landmarks and a range helper.
package fsm_sequence_checker_param_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXP_OPND = 2'd1,
    ST_EXP_OPR  = 2'd2,
    ST_ERR      = 2'd3
  } state_e;

  localparam logic [2:0] ERR_OK        = 3'd0;
  localparam logic [2:0] ERR_BAD_CHAR  = 3'd1;
  localparam logic [2:0] ERR_ORDER     = 3'd2;
  localparam logic [2:0] ERR_TOO_SHORT = 3'd3;
  localparam logic [2:0] ERR_TOO_LONG  = 3'd4;

  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_STAR  = 8'h2A;
  localparam logic [7:0] ASCII_SLASH = 8'h2F;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_UA    = 8'h41;
  localparam logic [7:0] ASCII_UF    = 8'h46;
  localparam logic [7:0] ASCII_LA    = 8'h61;
  localparam logic [7:0] ASCII_LF    = 8'h66;

  function automatic logic in_range(input logic [7:0] c, input logic [7:0] lo,
                                    input logic [7:0] hi);
    return (c >= lo) && (c <= hi);
  endfunction

endpackage

// File: rtl/fsm_sequence_checker_param_classifier.sv
// Combinational character classifier: splits a character into delimiter, hex digit
// or operator. The delimiter takes precedence so a DELIM overlapping a class stays a DELIM.
module fsm_sequence_checker_param_classifier
  import fsm_sequence_checker_param_pkg::*;
#(
  parameter logic [7:0] DELIM    = 8'h0A,
  parameter bit         LOWER_OK = 1'b0
) (
  input  logic [7:0] char_i,
  output logic       is_delim_o,
  output logic       is_hex_o,
  output logic       is_op_o
);

  logic hex_raw_s;
  logic op_raw_s;

  // Raw class decode, then mask hex/op with the delimiter decision
  always_comb begin
    hex_raw_s = in_range(char_i, ASCII_0, ASCII_9) || in_range(char_i, ASCII_UA, ASCII_UF);
    if (LOWER_OK) begin
      hex_raw_s = hex_raw_s || in_range(char_i, ASCII_LA, ASCII_LF);
    end else begin
      hex_raw_s = hex_raw_s;
    end
    op_raw_s   = (char_i == ASCII_PLUS) || (char_i == ASCII_MINUS) ||
                 (char_i == ASCII_STAR) || (char_i == ASCII_SLASH);
    is_delim_o = (char_i == DELIM);
    is_hex_o   = hex_raw_s && !is_delim_o;
    is_op_o    = op_raw_s && !is_delim_o;
  end

endmodule

// File: rtl/fsm_sequence_checker_param.sv
// Frame checker for DELIM-framed character streams: validates body class, operand/operator
// order and length, and reports a registered per-frame verdict plus saturating frame counters.
module fsm_sequence_checker_param
  import fsm_sequence_checker_param_pkg::*;
#(
  parameter logic [7:0]   DELIM    = 8'h0A,
  parameter int unsigned  MODE     = 1,
  parameter int unsigned  MIN_LEN  = 1,
  parameter int unsigned  MAX_LEN  = 32,
  parameter int unsigned  LOWER_OK = 0,
  parameter int unsigned  CNT_W    = 8,
  localparam int unsigned LEN_W    = $clog2(MAX_LEN + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       ascii_char,
  input  logic             char_valid,
  output logic             sequence_valid,
  output logic             output_strobe,
  output logic [2:0]       err_code,
  output logic [LEN_W-1:0] frame_len,
  output logic             in_frame,
  output logic [CNT_W-1:0] frames_ok,
  output logic [CNT_W-1:0] frames_bad
);

  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] LEN_SAT  = LEN_W'(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MIN  = LEN_W'(MIN_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam bit               ALT_MODE = (MODE == 32'd1);

  logic is_delim_s, is_hex_s, is_op_s;

  state_e           state_q, state_d, body_state_s;
  logic [LEN_W-1:0] len_q, len_d, len_inc_s;
  logic [2:0]       err_q, err_d, body_err_s, verdict_s;
  logic             seq_valid_q, seq_valid_d;
  logic             strobe_q, strobe_d;
  logic [2:0]       err_code_q, err_code_d;
  logic [LEN_W-1:0] frame_len_q, frame_len_d;
  logic             in_frame_q, in_frame_d;
  logic [CNT_W-1:0] ok_q, ok_d, bad_q, bad_d;

  fsm_sequence_checker_param_classifier #(
    .DELIM    (DELIM),
    .LOWER_OK (LOWER_OK != 0)
  ) u_classifier (
    .char_i     (ascii_char),
    .is_delim_o (is_delim_s),
    .is_hex_o   (is_hex_s),
    .is_op_o    (is_op_s)
  );

  // Saturating body length increment
  always_comb begin
    if (len_q == LEN_SAT) begin
      len_inc_s = LEN_SAT;
    end else begin
      len_inc_s = len_q + LEN_ONE;
    end
  end

  // Verdict of the frame being closed; a latched error always wins
  always_comb begin
    if (err_q != ERR_OK) begin
      verdict_s = err_q;
    end else if (ALT_MODE && (state_q == ST_EXP_OPND) && (len_q != LEN_ZERO)) begin
      verdict_s = ERR_ORDER;
    end else if (len_q < LEN_MIN) begin
      verdict_s = ERR_TOO_SHORT;
    end else begin
      verdict_s = ERR_OK;
    end
  end

  // Body-character step: class/order transition, then overflow check.
  // A class error on the overflowing character takes precedence over TOO_LONG.
  always_comb begin
    body_state_s = state_q;
    body_err_s   = ERR_OK;
    case (state_q)
      ST_EXP_OPND: begin
        if (is_hex_s) begin
          body_state_s = ALT_MODE ? ST_EXP_OPR : ST_EXP_OPND;
        end else if (is_op_s) begin
          body_state_s = ST_ERR;
          body_err_s   = ALT_MODE ? ERR_ORDER : ERR_BAD_CHAR;
        end else begin
          body_state_s = ST_ERR;
          body_err_s   = ERR_BAD_CHAR;
        end
      end
      ST_EXP_OPR: begin
        if (is_op_s) begin
          body_state_s = ST_EXP_OPND;
        end else if (is_hex_s) begin
          body_state_s = ST_ERR;
          body_err_s   = ERR_ORDER;
        end else begin
          body_state_s = ST_ERR;
          body_err_s   = ERR_BAD_CHAR;
        end
      end
      default: begin
        body_state_s = state_q;
        body_err_s   = ERR_OK;
      end
    endcase
    if ((state_q == ST_EXP_OPND || state_q == ST_EXP_OPR) &&
        (body_err_s == ERR_OK) && (len_inc_s == LEN_SAT)) begin
      body_state_s = ST_ERR;
      body_err_s   = ERR_TOO_LONG;
    end else begin
      body_state_s = body_state_s;
    end
  end

  // Frame open/close sequencing, verdict capture and counters
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    err_d       = err_q;
    seq_valid_d = seq_valid_q;
    strobe_d    = 1'b0;
    err_code_d  = err_code_q;
    frame_len_d = frame_len_q;
    ok_d        = ok_q;
    bad_d       = bad_q;
    if (char_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (is_delim_s) begin
            state_d = ST_EXP_OPND;
            len_d   = LEN_ZERO;
            err_d   = ERR_OK;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          if (is_delim_s) begin
            state_d     = ST_IDLE;
            strobe_d    = 1'b1;
            seq_valid_d = (verdict_s == ERR_OK);
            err_code_d  = verdict_s;
            frame_len_d = len_q;
            if (verdict_s == ERR_OK) begin
              ok_d = (ok_q == CNT_MAX) ? ok_q : ok_q + CNT_ONE;
            end else begin
              bad_d = (bad_q == CNT_MAX) ? bad_q : bad_q + CNT_ONE;
            end
          end else begin
            state_d = body_state_s;
            len_d   = len_inc_s;
            err_d   = (body_err_s != ERR_OK) ? body_err_s : err_q;
          end
        end
      endcase
    end else begin
      state_d = state_q;
    end
    in_frame_d = (state_d != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      len_q       <= LEN_ZERO;
      err_q       <= ERR_OK;
      seq_valid_q <= 1'b0;
      strobe_q    <= 1'b0;
      err_code_q  <= ERR_OK;
      frame_len_q <= LEN_ZERO;
      in_frame_q  <= 1'b0;
      ok_q        <= {CNT_W{1'b0}};
      bad_q       <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      err_q       <= err_d;
      seq_valid_q <= seq_valid_d;
      strobe_q    <= strobe_d;
      err_code_q  <= err_code_d;
      frame_len_q <= frame_len_d;
      in_frame_q  <= in_frame_d;
      ok_q        <= ok_d;
      bad_q       <= bad_d;
    end
  end

  assign sequence_valid = seq_valid_q;
  assign output_strobe  = strobe_q;
  assign err_code       = err_code_q;
  assign frame_len      = frame_len_q;
  assign in_frame       = in_frame_q;
  assign frames_ok      = ok_q;
  assign frames_bad     = bad_q;

endmodule

// File: tb/tb_fsm_sequence_checker_param.sv
// Scoreboard bench for the frame checker: three parameterisations (MODE1 default,
// MODE0 short/lowercase, 2-bit counters) driven with ASCII strings.
module tb_fsm_sequence_checker_param;

  typedef struct {
    int         inst;
    logic       valid;
    logic [2:0] err;
    int         len;
    int         ok;
    int         bad;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [7:0] ch_s  [3];
  logic       vld_s [3];

  logic       sv_s  [3];
  logic       st_s  [3];
  logic       inf_s [3];
  logic [2:0] ec_s  [3];
  int         fl_s  [3];
  int         ok_s  [3];
  int         bad_s [3];

  logic [5:0] len_a, len_c;
  logic [2:0] len_b;
  logic [7:0] ok_a, bad_a, ok_b, bad_b;
  logic [1:0] ok_c, bad_c;

  int   num_checks = 0;
  int   num_errors = 0;
  exp_t exp_q[$];
  int   exp_ok  [3] = '{0, 0, 0};
  int   exp_bad [3] = '{0, 0, 0};
  int   cnt_max [3] = '{255, 255, 3};

  fsm_sequence_checker_param #(.MODE(1)) dut_a (
    .clk(clk), .rst(rst), .ascii_char(ch_s[0]), .char_valid(vld_s[0]),
    .sequence_valid(sv_s[0]), .output_strobe(st_s[0]), .err_code(ec_s[0]),
    .frame_len(len_a), .in_frame(inf_s[0]), .frames_ok(ok_a), .frames_bad(bad_a)
  );

  fsm_sequence_checker_param #(.MODE(0), .MIN_LEN(2), .MAX_LEN(4), .LOWER_OK(1)) dut_b (
    .clk(clk), .rst(rst), .ascii_char(ch_s[1]), .char_valid(vld_s[1]),
    .sequence_valid(sv_s[1]), .output_strobe(st_s[1]), .err_code(ec_s[1]),
    .frame_len(len_b), .in_frame(inf_s[1]), .frames_ok(ok_b), .frames_bad(bad_b)
  );

  fsm_sequence_checker_param #(.MODE(1), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .ascii_char(ch_s[2]), .char_valid(vld_s[2]),
    .sequence_valid(sv_s[2]), .output_strobe(st_s[2]), .err_code(ec_s[2]),
    .frame_len(len_c), .in_frame(inf_s[2]), .frames_ok(ok_c), .frames_bad(bad_c)
  );

  assign fl_s[0]  = int'(len_a);
  assign fl_s[1]  = int'(len_b);
  assign fl_s[2]  = int'(len_c);
  assign ok_s[0]  = int'(ok_a);
  assign ok_s[1]  = int'(ok_b);
  assign ok_s[2]  = int'(ok_c);
  assign bad_s[0] = int'(bad_a);
  assign bad_s[1] = int'(bad_b);
  assign bad_s[2] = int'(bad_c);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input int obs, input int expv);
    num_checks++;
    if (obs != expv) begin
      num_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Push the expected verdict of one frame; counters follow the saturating rule
  task automatic expect_frame(input int i, input logic [2:0] err, input int len);
    exp_t e;
    if (err == 3'd0) begin
      if (exp_ok[i] < cnt_max[i]) exp_ok[i]++;
    end else begin
      if (exp_bad[i] < cnt_max[i]) exp_bad[i]++;
    end
    e.inst  = i;
    e.valid = (err == 3'd0);
    e.err   = err;
    e.len   = len;
    e.ok    = exp_ok[i];
    e.bad   = exp_bad[i];
    exp_q.push_back(e);
  endtask

  task automatic send_str(input int i, input string s);
    for (int k = 0; k < s.len(); k++) begin
      ch_s[i]  = s[k];
      vld_s[i] = 1'b1;
      @(posedge clk);
      #1;
    end
    vld_s[i] = 1'b0;
  endtask

  task automatic check_zero(input int i);
    check_value($sformatf("rst_i%0d_valid", i), int'(sv_s[i]), 0);
    check_value($sformatf("rst_i%0d_strobe", i), int'(st_s[i]), 0);
    check_value($sformatf("rst_i%0d_err", i), int'(ec_s[i]), 0);
    check_value($sformatf("rst_i%0d_inframe", i), int'(inf_s[i]), 0);
    check_value($sformatf("rst_i%0d_len", i), fl_s[i], 0);
    check_value($sformatf("rst_i%0d_ok", i), ok_s[i], 0);
    check_value($sformatf("rst_i%0d_bad", i), bad_s[i], 0);
  endtask

  // Scoreboard: every strobe pops one expected verdict and compares it
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        if (st_s[i]) begin
          if (exp_q.size() == 0) begin
            check_value($sformatf("i%0d_strobe_unexpected", i), 1, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check_value($sformatf("i%0d_strobe_inst", i), i, e.inst);
            check_value($sformatf("i%0d_valid", i), int'(sv_s[i]), int'(e.valid));
            check_value($sformatf("i%0d_err", i), int'(ec_s[i]), int'(e.err));
            check_value($sformatf("i%0d_len", i), fl_s[i], e.len);
            check_value($sformatf("i%0d_ok", i), ok_s[i], e.ok);
            check_value($sformatf("i%0d_bad", i), bad_s[i], e.bad);
          end
        end
      end
    end
  end

  initial begin
    string s;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ch_s[i]  = 8'h00;
      vld_s[i] = 1'b0;
    end
    #3;
    for (int i = 0; i < 3; i++) check_zero(i);
    #4 rst = 1'b1;
    @(posedge clk);
    #1;

    // Instance A: MODE1, MIN_LEN 1, MAX_LEN 32
    expect_frame(0, 3'd0, 9);
    send_str(0, "\021");
    check_value("a_inframe_ignored", int'(inf_s[0]), 0);
    send_str(0, "\nA+F+F+F+F");
    check_value("a_inframe_open", int'(inf_s[0]), 1);
    send_str(0, "\n");
    check_value("a_inframe_closed", int'(inf_s[0]), 0);
    expect_frame(0, 3'd2, 2);
    send_str(0, "\nA+\n");
    expect_frame(0, 3'd1, 3);
    send_str(0, "\nAGF\n");
    expect_frame(0, 3'd3, 0);
    send_str(0, "\n\n");
    expect_frame(0, 3'd2, 1);
    send_str(0, "\n+\n");
    expect_frame(0, 3'd1, 1);
    send_str(0, "\na\n");
    expect_frame(0, 3'd2, 2);
    send_str(0, "\nAA\n");
    s = "\n";
    for (int k = 0; k < 16; k++) s = {s, "1+"};
    s = {s, "1+2\n"};
    expect_frame(0, 3'd4, 33);
    send_str(0, s);
    s = "\n";
    for (int k = 0; k < 15; k++) s = {s, "1+"};
    s = {s, "1\n"};
    expect_frame(0, 3'd0, 31);
    send_str(0, s);

    // Async reset mid-frame drops the frame without a strobe
    send_str(0, "\nA");
    check_value("a_pre_rst_inframe", int'(inf_s[0]), 1);
    check_value("a_pre_rst_ok", ok_s[0], 2);
    check_value("a_pre_rst_bad", bad_s[0], 7);
    #2 rst = 1'b0;
    #1;
    check_zero(0);
    for (int i = 0; i < 3; i++) begin
      exp_ok[i]  = 0;
      exp_bad[i] = 0;
    end
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    expect_frame(0, 3'd0, 3);
    send_str(0, "xyz");
    send_str(0, "\n");
    send_str(0, "9/A");
    send_str(0, "\n");

    // Instance B: MODE0, MIN_LEN 2, MAX_LEN 4, lowercase accepted
    expect_frame(1, 3'd4, 5);
    send_str(1, "\n111111\n");
    expect_frame(1, 3'd0, 4);
    send_str(1, "\n1111\n");
    expect_frame(1, 3'd1, 2);
    send_str(1, "\n1+\n");
    expect_frame(1, 3'd0, 2);
    send_str(1, "\naF\n");
    expect_frame(1, 3'd3, 1);
    send_str(1, "\n7\n");
    expect_frame(1, 3'd1, 2);
    send_str(1, "\ng1\n");
    expect_frame(1, 3'd4, 5);
    send_str(1, "\n11111+\n");

    // Instance C: 2-bit counters saturate at 3, char_valid held high throughout
    s = "";
    for (int k = 0; k < 5; k++) begin
      expect_frame(2, 3'd0, 1);
      s = {s, "\n1\n"};
    end
    for (int k = 0; k < 4; k++) begin
      expect_frame(2, 3'd2, 1);
      s = {s, "\n+\n"};
    end
    send_str(2, s);

    repeat (4) @(posedge clk);
    #1;
    check_value("pending_expect", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
